// File: rtl/dump_pkg.sv
// Shared definitions for the architectural-state dumper.
//
// Contents:
//   DEFAULT_XLEN  default data word width
//   TAG_*         out_tag values: register beat, memory beat, checksum beat
//   dump_state_e  FSM state encoding for arch_state_dumper
//
// Optional feature macro: DUMP_CHECKSUM_EN adds the ST_CSUM state.
package dump_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [1:0] TAG_REG  = 2'd0;
  localparam logic [1:0] TAG_MEM  = 2'd1;
  localparam logic [1:0] TAG_CSUM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HALT = 3'd1,
    ST_REG  = 3'd2,
    ST_MEM  = 3'd3,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_FIN  = 3'd5
  } dump_state_e;

endpackage

// File: rtl/arch_state_dumper_if.sv
// Valid/ready beat stream carrying the architectural-state dump.
//
// Signals:
//   out_valid  beat valid (producer)
//   out_ready  consumer accepts beat (consumer)
//   out_data   beat payload, XLEN bits
//   out_tag    0 = register, 1 = memory, 2 = checksum
//   out_idx    register number / memory word index (0 for checksum)
//   out_last   final beat of the dump
//
// Modports: master = producer (dumper), slave = consumer.
interface arch_state_dumper_if
  import dump_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int IDX_W = 8
);

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [1:0]       out_tag;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_tag, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_tag, out_idx, out_last,
    output out_ready
  );

endinterface

// File: rtl/dump_out_stage.sv
// Registered valid/ready output stage for a tagged beat stream.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       capture in_* this cycle (caller only asserts it while can_load)
//   in_data    payload to capture
//   in_tag     tag to capture
//   in_idx     index to capture
//   in_last    last-beat flag to capture
//   can_load   register is empty or is being drained this cycle
//   out_if     stream master driven from the registers
//
// While a beat is valid and not accepted the registers hold unchanged.
module dump_out_stage
  import dump_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int IDX_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [XLEN-1:0]     in_data,
  input  logic [1:0]          in_tag,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic                in_last,
  output logic                can_load,
  arch_state_dumper_if.master out_if
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [1:0]       tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;

  assign can_load = !valid_q || out_if.out_ready;

  // A new beat replaces the current one when requested; otherwise an
  // accepted beat simply empties the register and the payload is kept.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      tag_d   = in_tag;
      idx_d   = in_idx;
      last_d  = in_last;
    end else if (out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= TAG_REG;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_tag   = tag_q;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = last_q;

endmodule

// File: rtl/arch_state_dumper.sv
// Architectural-state dumper: halts the CPU, then streams register file
// x0..x(NUM_REGS-1) followed by data memory words 0..DMEM_WORDS-1.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle dump request, honoured only when idle
//   busy       dump in progress
//   done       one-cycle pulse after the final beat is accepted
//   cpu_halt   freezes the CPU while high
//   rf_raddr   RF debug read address;   rf_rdata combinational RF data
//   dm_raddr   DMEM debug word address; dm_rdata combinational DMEM data
//   dump_out   beat stream (valid/ready, data, tag, idx, last)
//
// Optional feature macro DUMP_CHECKSUM_EN: append a beat carrying the
// mod-2^XLEN sum of all payloads; otherwise the last memory beat ends the dump.
module arch_state_dumper
  import dump_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int NUM_REGS   = 32,
  parameter int DMEM_WORDS = 32,
  parameter int IDX_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                cpu_halt,
  output logic [4:0]          rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  output logic [IDX_W-1:0]    dm_raddr,
  input  logic [XLEN-1:0]     dm_rdata,
  arch_state_dumper_if.master dump_out
);

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(DMEM_WORDS - 1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             halt_q, halt_d;
  logic             done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [XLEN-1:0]  sum_q, sum_d;
`endif

  logic             streaming;
  logic             can_load;
  logic             load;
  logic [XLEN-1:0]  beat_data;
  logic [1:0]       beat_tag;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_last;

`ifdef DUMP_CHECKSUM_EN
  assign streaming = (state_q == ST_REG) || (state_q == ST_MEM) || (state_q == ST_CSUM);
`else
  assign streaming = (state_q == ST_REG) || (state_q == ST_MEM);
`endif
  assign load = streaming && can_load;

  assign rf_raddr = (state_q == ST_REG) ? idx_q[4:0] : 5'd0;
  assign dm_raddr = (state_q == ST_MEM) ? idx_q : '0;

  // Next-state logic: the walk index advances only on beats the output
  // stage actually captures, so backpressure just pauses the walk.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    halt_d    = halt_q;
    done_d    = 1'b0;
    beat_data = '0;
    beat_tag  = TAG_REG;
    beat_idx  = idx_q;
    beat_last = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HALT;
          busy_d  = 1'b1;
          halt_d  = 1'b1;
        end
      end
      ST_HALT: begin
        idx_d   = '0;
        state_d = ST_REG;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      ST_REG: begin
        beat_data = rf_rdata;
        beat_tag  = TAG_REG;
        if (load) begin
`ifdef DUMP_CHECKSUM_EN
          sum_d = sum_q + rf_rdata;
`endif
          if (idx_q == LAST_REG) begin
            idx_d   = '0;
            state_d = ST_MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_MEM: begin
        beat_data = dm_rdata;
        beat_tag  = TAG_MEM;
`ifndef DUMP_CHECKSUM_EN
        beat_last = (idx_q == LAST_MEM);
`endif
        if (load) begin
`ifdef DUMP_CHECKSUM_EN
          sum_d = sum_q + dm_rdata;
`endif
          if (idx_q == LAST_MEM) begin
            idx_d = '0;
`ifdef DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        beat_data = sum_q;
        beat_tag  = TAG_CSUM;
        beat_idx  = '0;
        beat_last = 1'b1;
        if (load) begin
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        // The final beat is already in the output register; leave once it
        // is accepted, releasing the CPU in the same cycle done pulses.
        if (dump_out.out_valid && dump_out.out_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          halt_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        halt_d  = 1'b0;
      end
    endcase
  end

  // FSM state, walk index and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign cpu_halt = halt_q;
  assign done     = done_q;

  dump_out_stage #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W)
  ) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in_data  (beat_data),
    .in_tag   (beat_tag),
    .in_idx   (beat_idx),
    .in_last  (beat_last),
    .can_load (can_load),
    .out_if   (dump_out)
  );

endmodule

// File: tb/tb_arch_state_dumper.sv
// Self-checking bench for arch_state_dumper. RF and DMEM are modelled as
// arrays with combinational reads; the expected beat list is derived
// directly from the array contents. Honours DUMP_CHECKSUM_EN.
module tb_arch_state_dumper;
  import dump_pkg::*;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int DMEM_WORDS = 32;
  localparam int IDX_W      = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int NBEATS = NUM_REGS + DMEM_WORDS + 1;
`else
  localparam int NBEATS = NUM_REGS + DMEM_WORDS;
`endif

  typedef struct packed {
    logic [1:0]       tag;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             cpu_halt;
  logic [4:0]       rf_raddr;
  logic [XLEN-1:0]  rf_rdata;
  logic [IDX_W-1:0] dm_raddr;
  logic [XLEN-1:0]  dm_rdata;

  logic [XLEN-1:0] rf_mem [NUM_REGS];
  logic [XLEN-1:0] dm_mem [DMEM_WORDS];

  int    tests = 0;
  int    fails = 0;
  int    ready_mode = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  bit    done_exp = 1'b0;
  bit    prev_stall = 1'b0;
  bit    post_rst = 1'b0;
  beat_t prev_beat;
  beat_t exp_q [$];
  beat_t got_q [$];

  arch_state_dumper_if #(.XLEN(XLEN), .IDX_W(IDX_W)) dump_out ();

  arch_state_dumper #(
    .XLEN       (XLEN),
    .NUM_REGS   (NUM_REGS),
    .DMEM_WORDS (DMEM_WORDS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cpu_halt (cpu_halt),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .dm_raddr (dm_raddr),
    .dm_rdata (dm_rdata),
    .dump_out (dump_out)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_raddr];
  assign dm_rdata = dm_mem[dm_raddr[4:0]];

  function automatic beat_t mkBeat(input logic [1:0] tag, input int idx,
                                   input logic [XLEN-1:0] data, input logic last);
    beat_t b;
    b.tag  = tag;
    b.idx  = IDX_W'(idx);
    b.data = data;
    b.last = last;
    return b;
  endfunction

  // Expected dump: every register, then every memory word, optionally a
  // checksum beat; the final beat carries the last flag.
  function automatic void buildModel();
    logic [XLEN-1:0] sum;
    sum = '0;
    exp_q.delete();
    for (int r = 0; r < NUM_REGS; r++) begin
      exp_q.push_back(mkBeat(TAG_REG, r, rf_mem[r], 1'b0));
      sum += rf_mem[r];
    end
    for (int m = 0; m < DMEM_WORDS; m++) begin
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(mkBeat(TAG_MEM, m, dm_mem[m], 1'b0));
`else
      exp_q.push_back(mkBeat(TAG_MEM, m, dm_mem[m], m == DMEM_WORDS - 1));
`endif
      sum += dm_mem[m];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(mkBeat(TAG_CSUM, 0, sum, 1'b1));
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Consumer ready pattern: always ready, alternating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dump_out.out_ready = 1'b1;
      1:       dump_out.out_ready = ~dump_out.out_ready;
      default: dump_out.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Per-cycle monitor: scores handshaken beats against the model, checks
  // stall stability, done timing and the post-reset quiet state.
  always @(negedge clk) begin
    beat_t cur;
    cur.tag  = dump_out.out_tag;
    cur.idx  = dump_out.out_idx;
    cur.data = dump_out.out_data;
    cur.last = dump_out.out_last;
    if (post_rst) begin
      checkOutput("reset_quiet", {60'd0, dump_out.out_valid, busy, cpu_halt, done}, 64'd0);
      post_rst = 1'b0;
    end else begin
      checkOutput("done_pulse", {63'd0, done}, {63'd0, done_exp});
      checkOutput("halt_eq_busy", {63'd0, cpu_halt}, {63'd0, busy});
      if (dump_out.out_valid && prev_stall)
        checkOutput("hold_stable", 64'(cur), 64'(prev_beat));
    end
    if (done) done_cnt++;
    done_exp = 1'b0;
    if (rst) begin
      prev_stall = 1'b0;
      post_rst   = 1'b1;
    end else begin
      if (dump_out.out_valid && dump_out.out_ready) begin
        if (beat_cnt < exp_q.size())
          checkOutput($sformatf("beat%0d", beat_cnt), 64'(cur), 64'(exp_q[beat_cnt]));
        else
          checkOutput("extra_beat", 64'(beat_cnt), 64'(exp_q.size()));
        got_q.push_back(cur);
        if (cur.last) done_exp = 1'b1;
        beat_cnt++;
      end
      prev_stall = dump_out.out_valid && !dump_out.out_ready;
      prev_beat  = cur;
    end
  end

  // Runs one dump. restart_beat >= 0 re-pulses start at that beat;
  // reset_beat >= 0 asserts rst at that beat and abandons the dump.
  task automatic applyStimulus(input int mode, input int restart_beat, input int reset_beat);
    int cyc;
    bit restarted;
    cyc       = 0;
    restarted = 1'b0;
    buildModel();
    got_q.delete();
    beat_cnt   = 0;
    done_cnt   = 0;
    ready_mode = mode;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    checkOutput("halt_after_start", {63'd0, cpu_halt}, 64'd1);
    checkOutput("valid_lat_c1", {63'd0, dump_out.out_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("valid_lat_c2", {63'd0, dump_out.out_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("valid_lat_c3", {63'd0, dump_out.out_valid}, 64'd1);
    cyc = 3;
    while (!done && cyc < 3000) begin
      if (reset_beat >= 0 && beat_cnt >= reset_beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_valid", {63'd0, dump_out.out_valid}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_halt", {63'd0, cpu_halt}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_done", 64'(done_cnt), 64'd0);
        return;
      end
      if (restart_beat >= 0 && beat_cnt >= restart_beat && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    checkOutput("dump_timeout", {63'd0, done}, 64'd1);
    @(negedge clk); #1;
    checkOutput("beat_count", 64'(beat_cnt), 64'(NBEATS));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("done_count", 64'(done_cnt), 64'd1);
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_valid", {63'd0, dump_out.out_valid}, 64'd0);
  endtask

  task automatic preloadBasic();
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    for (int i = 0; i < DMEM_WORDS; i++) dm_mem[i] = '0;
    for (int i = 1; i <= 4; i++) rf_mem[i] = XLEN'(i);
    dm_mem[2] = 32'h0000_5678;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dump_out.out_ready = 1'b0;
    preloadBasic();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pins against hand-computed values.
    buildModel();
    checkOutput("model_size", 64'(exp_q.size()), 64'(NBEATS));
    checkOutput("model_beat1", 64'(exp_q[1]), 64'(mkBeat(2'd0, 1, 32'h1, 1'b0)));
    checkOutput("model_beat34", 64'(exp_q[34]), 64'(mkBeat(2'd1, 2, 32'h5678, 1'b0)));
`ifdef DUMP_CHECKSUM_EN
    checkOutput("model_csum", 64'(exp_q[64]), 64'(mkBeat(2'd2, 0, 32'h5682, 1'b1)));
`endif

    // Basic dump with the consumer always ready.
    applyStimulus(0, -1, -1);
    if (got_q.size() >= NBEATS) begin
      checkOutput("dut_beat1", 64'(got_q[1]), 64'(mkBeat(2'd0, 1, 32'h1, 1'b0)));
      checkOutput("dut_beat34", 64'(got_q[34]), 64'(mkBeat(2'd1, 2, 32'h5678, 1'b0)));
`ifdef DUMP_CHECKSUM_EN
      checkOutput("dut_beat63_last", {63'd0, got_q[63].last}, 64'd0);
      checkOutput("dut_csum", 64'(got_q[64]), 64'(mkBeat(2'd2, 0, 32'h5682, 1'b1)));
`else
      checkOutput("dut_beat63_last", {63'd0, got_q[63].last}, 64'd1);
`endif
    end else begin
      checkOutput("dut_beats_present", 64'(got_q.size()), 64'(NBEATS));
    end

    // Alternating backpressure.
    applyStimulus(1, -1, -1);

    // Second start while busy is ignored.
    applyStimulus(0, 10, -1);

    // Reset mid-dump, then a clean restart from x0.
    applyStimulus(0, -1, 20);
    applyStimulus(0, -1, -1);
    if (got_q.size() > 0)
      checkOutput("restart_first", 64'(got_q[0]), 64'(mkBeat(2'd0, 0, rf_mem[0], 1'b0)));
    else
      checkOutput("restart_present", 64'(got_q.size()), 64'(NBEATS));

    // Random contents (x0 included) with random backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
      for (int i = 0; i < DMEM_WORDS; i++) dm_mem[i] = $urandom;
      applyStimulus(2, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
